// File: rtl/dmem_dump_streamer.sv
// Walks a window of data BRAM through its debug read port and streams each word out as
// little-endian bytes on a valid/ready port. Define DMEM_DUMP_CHECKSUM_EN to append a two's-complement checksum byte.
module dmem_dump_streamer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int BRAM_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH-1:0] debug_addr,
    input  logic [DATA_WIDTH-1:0] debug_data,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LATCH  = 3'd2,
        S_SEND   = 3'd3,
`ifdef DMEM_DUMP_CHECKSUM_EN
        S_CKSUM  = 3'd4,
`endif
        S_FINISH = 3'd5
    } state_t;

    localparam logic [1:0]            WAIT_LAST  = 2'(BRAM_RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH:0]   ONE_WORD   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] debug_addr_q, debug_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic [31:0]           shreg_q, shreg_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  handshake_s;
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    assign handshake_s = m_valid_q & m_ready;

    // Next-state and datapath: every output comes straight from a flop
    always_comb begin
        state_d      = state_q;
        debug_addr_d = debug_addr_q;
        remaining_d  = remaining_q;
        wait_cnt_d   = wait_cnt_q;
        shreg_d      = shreg_q;
        byte_idx_d   = byte_idx_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
                if (start && (word_count != '0)) begin
                    debug_addr_d = base_addr & ALIGN_MASK;
                    remaining_d  = word_count;
                    wait_cnt_d   = 2'd0;
                    busy_d       = 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d        = 8'd0;
`endif
                    state_d      = S_WAIT;
                end else if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_LATCH: begin
                shreg_d    = debug_data[31:0];
                byte_idx_d = 2'd0;
                m_data_d   = debug_data[7:0];
                m_valid_d  = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (handshake_s) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                    sum_d = sum_q + m_data_q;
`endif
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shreg_d    = {8'h00, shreg_q[31:8]};
                        m_data_d   = shreg_q[15:8];
                    end else begin
                        // Address wraps naturally at the top of the BRAM
                        remaining_d  = remaining_q - ONE_WORD;
                        debug_addr_d = debug_addr_q + WORD_STEP;
                        if (remaining_q != ONE_WORD) begin
                            wait_cnt_d = 2'd0;
                            m_valid_d  = 1'b0;
                            state_d    = S_WAIT;
                        end else begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                            m_data_d = ~(sum_q + m_data_q) + 8'd1;
                            state_d  = S_CKSUM;
`else
                            m_valid_d = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            state_d   = S_FINISH;
`endif
                        end
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
`ifdef DMEM_DUMP_CHECKSUM_EN
            S_CKSUM: begin
                if (handshake_s) begin
                    m_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    state_d = S_CKSUM;
                end
            end
`endif
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any dump without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            debug_addr_q <= '0;
            remaining_q  <= '0;
            wait_cnt_q   <= 2'd0;
            shreg_q      <= 32'd0;
            byte_idx_q   <= 2'd0;
            m_data_q     <= 8'd0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            debug_addr_q <= debug_addr_d;
            remaining_q  <= remaining_d;
            wait_cnt_q   <= wait_cnt_d;
            shreg_q      <= shreg_d;
            byte_idx_q   <= byte_idx_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign debug_addr = debug_addr_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// Directed bench for dmem_dump_streamer with a latency-1 BRAM model and a negedge stream monitor.
module tb_dmem_dump_streamer;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;

    dmem_dump_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BRAM_RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .debug_addr(debug_addr), .debug_data(debug_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) debug_data <= mem[debug_addr[9:2]];

    // Stream monitor
    logic [7:0] byte_q [$];
    logic [9:0] addr_q [$];
    int         gap_q  [$];
    int hs_count = 0, low_run = 0, done_cnt = 0, stab_err = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_v   = 1'b0;
            low_run  = 0;
            hs_count = 0;
        end else begin
            if (prev_v && !prev_r && (!m_valid || m_data !== prev_d)) stab_err++;
            if (m_valid && m_ready) begin
                if (hs_count % 4 == 0 && hs_count > 0) gap_q.push_back(low_run);
                byte_q.push_back(m_data);
                addr_q.push_back(debug_addr);
                low_run = 0;
                hs_count++;
            end else if (!m_valid) begin
                low_run++;
            end
            if (done) begin
                done_cnt++;
                hs_count = 0;
                low_run  = 0;
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end
    end

    int n_checks = 0, n_fail = 0;
    int b0, g0, d0, s0, first_n, done_n;
    logic busy_at_done;
    logic [3:0] pat = 4'b1001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_dump(input logic [9:0] base, input logic [10:0] cnt, input bit bp, input bit poke);
        b0 = byte_q.size(); g0 = gap_q.size(); d0 = done_cnt; s0 = stab_err;
        first_n = -1; done_n = -1; busy_at_done = 1'bx;
        @(posedge clk); #1;
        base_addr = base; word_count = cnt; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 10'h3A0; word_count = 11'd7;
        for (int idx = 0; idx < 400 && done_n < 0; idx++) begin
            @(negedge clk);
            if (m_valid && first_n < 0) first_n = idx;
            if (done) begin done_n = idx; busy_at_done = busy; end
            @(posedge clk); #1;
            m_ready = bp ? pat[idx % 4] : 1'b1;
            if (poke && idx == 8) begin start = 1'b1; base_addr = 10'h3FC; word_count = 11'd2; end
            if (poke && idx == 9) start = 1'b0;
        end
        check("done_seen_before_timeout", 32'(done_n >= 0), 32'd1);
    endtask

    // Compares n data bytes (byte i = vec[8i+:8]) plus the checksum byte when enabled
    task automatic check_stream(input string tag, input logic [127:0] vec, input int n);
        logic [7:0] sum;
        logic [31:0] obs;
        int extra;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            obs = (b0 + i < byte_q.size()) ? {24'h0, byte_q[b0 + i]} : 32'hDEAD0000;
            check($sformatf("%s_byte%0d", tag, i), obs, {24'h0, vec[8*i +: 8]});
            sum = sum + vec[8*i +: 8];
        end
        extra = 0;
`ifdef DMEM_DUMP_CHECKSUM_EN
        extra = 1;
        obs = (b0 + n < byte_q.size()) ? {24'h0, byte_q[b0 + n]} : 32'hDEAD0000;
        check($sformatf("%s_cksum", tag), obs, {24'h0, 8'h00 - sum});
`endif
        check($sformatf("%s_len", tag), 32'(byte_q.size() - b0), 32'(n + extra));
        check($sformatf("%s_done_once", tag), 32'(done_cnt - d0), 32'd1);
        check($sformatf("%s_busy_at_done", tag), {31'h0, busy_at_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 10'h000; word_count = 11'd0; m_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h00000001; mem[1] = 32'h00000002; mem[2] = 32'h0020000C;
        mem[255] = 32'hDEADBEEF;
        #12;
        check("rst_m_valid", {31'h0, m_valid}, 32'd0);
        check("rst_debug_addr", {22'h0, debug_addr}, 32'd0);
        check("rst_busy_done", {30'h0, busy, done}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_m_valid", {31'h0, m_valid}, 32'd0);
        end

        // Basic 3-word dump; e0 samples start, WAIT at e1, LATCH captures at e2
        run_dump(10'h000, 11'd3, 1'b0, 1'b0);
        check("basic_first_valid", first_n, LAT + 1);
        check_stream("basic", 128'h0020000C_00000002_00000001, 12);
        check("basic_gap0", (gap_q.size() > g0) ? gap_q[g0] : -1, LAT + 1);
        check("basic_gap1", (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -1, LAT + 1);
        check("basic_addr_w1", {22'h0, addr_q[b0 + 4]}, 32'h004);
        check("basic_addr_w2", {22'h0, addr_q[b0 + 8]}, 32'h008);

        // Backpressure 1,0,0,1
        run_dump(10'h000, 11'd3, 1'b1, 1'b0);
        check_stream("bp", 128'h0020000C_00000002_00000001, 12);
        check("bp_stable", stab_err - s0, 0);

        // Wrap from the top word to address zero
        mem[0] = 32'h2F2FA000;
        run_dump(10'h3FC, 11'd2, 1'b0, 1'b0);
        check_stream("wrap", 128'h2F2FA000_DEADBEEF, 8);
        check("wrap_addr0", {22'h0, addr_q[b0]}, 32'h3FC);
        check("wrap_addr1", {22'h0, addr_q[b0 + 4]}, 32'h000);

        // Unaligned base behaves as aligned
        run_dump(10'h005, 11'd1, 1'b0, 1'b0);
        check_stream("unaligned", 128'h00000002, 4);
        check("unaligned_addr", {22'h0, addr_q[b0]}, 32'h004);

        // Zero count: done one cycle after start, nothing streamed
        run_dump(10'h000, 11'd0, 1'b0, 1'b0);
        check("zero_done_cycle", done_n, 0);
        check("zero_busy", {31'h0, busy_at_done}, 32'd0);
        check("zero_no_valid", first_n, -1);
        repeat (4) @(negedge clk);
        check("zero_len", byte_q.size() - b0, 0);
        check("zero_done_once", done_cnt - d0, 1);

        // Start pulsed mid-dump is ignored
        mem[0] = 32'h00000001;
        run_dump(10'h000, 11'd3, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_stream("ignored", 128'h0020000C_00000002_00000001, 12);

`ifdef DMEM_DUMP_CHECKSUM_EN
        mem[0] = 32'h00000003;
        run_dump(10'h000, 11'd1, 1'b0, 1'b0);
        check_stream("cksum", 128'h00000003, 4);
        check("cksum_fd", {24'h0, byte_q[b0 + 4]}, 32'h0FD);
`endif

        // Reset in the middle of a dump
        @(posedge clk); #1; base_addr = 10'h000; word_count = 11'd3; start = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_valid_before_rst", {31'h0, m_valid}, 32'd1);
        #2 rst = 1'b1;
        d0 = done_cnt;
        #1;
        check("mid_rst_outputs", {debug_addr, m_data, m_valid, busy, done}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; m_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", {30'h0, m_valid, busy}, 32'd0);
        check("post_rst_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
